alu_seq_ctrl: RTL

Byte-serial sequencer for the 8-bit combinational ALU (alu_8bits) behind the 8-bit TinyTapeout pin interface. It receives a command byte and operand bytes over one 8-bit valid/ready stream, and drives stable A, B and op-select into the ALU. After a fixed settle time it captures Result and presents it on a valid/ready result stream. It also keeps an accumulator for chained operations and an operation counter.

---
 rtl/alu_seq_pkg.sv | 12 +
 rtl/alu_seq_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state, op and command-field definitions for the ALU sequencer
package alu_seq_pkg;
   typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, DONE} state_t;
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;
   localparam int CMD_OP_LSB    = 0;
   localparam int CMD_CHAIN_BIT = 2;
   localparam int CMD_RSVD_MSB  = 7;
   localparam int CMD_RSVD_LSB  = 3;
endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: byte-serial command/operand sequencer driving an external combinational ALU
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [W-1:0] alu_result,
   output logic [W-1:0] res_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy,
   output logic         err,
   output logic [7:0]   op_count
);
   state_t       state;
   logic [1:0]   op;
   logic [3:0]   cnt;
   logic [W-1:0] acc;
   assign in_ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op        <= OP_ADD;
         cnt       <= '0;
         acc       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= OP_ADD;
         res_data  <= '0;
         res_valid <= 1'b0;
         err       <= 1'b0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               if (|in_data[CMD_RSVD_MSB:CMD_RSVD_LSB]) err <= 1'b1;
               else begin
                  op <= in_data[CMD_OP_LSB +: 2];
                  if (in_data[CMD_CHAIN_BIT]) begin
                     alu_a <= acc;
                     state <= GET_B;
                  end else state <= GET_A;
               end
            end
            GET_A: if (in_valid) begin
               alu_a <= in_data;
               state <= GET_B;
            end
            // ALU inputs are now complete; hold them for ALU_LAT cycles
            GET_B: if (in_valid) begin
               alu_b  <= in_data;
               alu_op <= op;
               cnt    <= 4'(ALU_LAT - 1);
               state  <= EXEC;
            end
            EXEC: if (cnt == 4'd0) begin
               res_data  <= alu_result;
               acc       <= alu_result;
               res_valid <= 1'b1;
               op_count  <= op_count + 8'd1;
               state     <= DONE;
            end else cnt <= cnt - 4'd1;
            DONE: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
